reg_bank_write_arbiter: RTL and testbench

Write controller for a bank of `R` enable-gated, `L`-bit data registers. It shares a single write path between `N` requesters using round-robin arbitration. It also provides a sequenced bulk clear that writes zero into every register. Its `reg_ena`/`reg_d` outputs drive the per-register enable and the common data input of the bank directly.

---
 rtl/reg_bank_write_arbiter.sv | 150 +++++++++++++++
 tb/tb_reg_bank_write_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter
//   Shares one write path into a bank of R enable-gated L-bit registers
//   between N requesters using round-robin arbitration. It also runs a
//   sequenced bulk clear that writes zero into every register, one
//   register per cycle.
//
// Ports
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   req      [N]         : per-requester write request (level)
//   req_addr [N*AW]      : requester i address in [i*AW +: AW]
//   req_data [N*L]       : requester i data in [i*L +: L]
//   clr_req              : bulk-clear request (level); wins over req
//   gnt      [N]         : one-cycle one-hot grant pulse (registered)
//   clr_done             : one-cycle pulse at the end of a clear (registered)
//   reg_ena  [R]         : one-hot (or zero) register write enable (registered)
//   reg_d    [L]         : common register write data (registered)
//   busy                 : high whenever the controller is not idle
module reg_bank_write_arbiter #(
  parameter int L  = 24,
  parameter int N  = 4,
  parameter int R  = 8,
  parameter int AW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*L-1:0] req_data,
  input  logic           clr_req,
  output logic [N-1:0]   gnt,
  output logic           clr_done,
  output logic [R-1:0]   reg_ena,
  output logic [L-1:0]   reg_d,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          clr_done_q, clr_done_d;
  logic [R-1:0]  reg_ena_q, reg_ena_d;
  logic [L-1:0]  reg_d_q, reg_d_d;

  // Round-robin search: first requester with req high, starting at ptr.
  logic          found;
  logic [PW-1:0] win;
  logic [AW-1:0] win_addr;
  logic [L-1:0]  win_data;

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    win_addr = req_addr[win*AW +: AW];
    win_data = req_data[win*L +: L];
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    clr_done_d = 1'b0;
    reg_ena_d  = '0;
    reg_d_d    = reg_d_q;   // data holds when no write is in progress

    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d      = CLEAR;
          cnt_d        = '0;
          reg_ena_d[0] = 1'b1;
          reg_d_d      = '0;
        end else if (found) begin
          state_d    = GRANT;
          gnt_d[win] = 1'b1;
          reg_d_d    = win_data;
          // Out-of-range addresses still get a grant; the write is dropped.
          if (int'(win_addr) < R) begin
            reg_ena_d[win_addr] = 1'b1;
          end
          ptr_d = PW'((int'(win) + 1) % N);
        end
      end

      // Outputs were valid for one cycle; defaults clear them.
      GRANT: state_d = IDLE;

      CLEAR: begin
        if (int'(cnt_q) < R - 1) begin
          cnt_d                       = cnt_q + AW'(1);
          reg_ena_d[cnt_q + AW'(1)]   = 1'b1;
          reg_d_d                     = '0;
        end else begin
          clr_done_d = 1'b1;
          state_d    = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      clr_done_q <= 1'b0;
      reg_ena_q  <= '0;
      reg_d_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      clr_done_q <= clr_done_d;
      reg_ena_q  <= reg_ena_d;
      reg_d_q    <= reg_d_d;
    end
  end

  assign gnt      = gnt_q;
  assign clr_done = clr_done_q;
  assign reg_ena  = reg_ena_q;
  assign reg_d    = reg_d_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Testbench for reg_bank_write_arbiter: directed reset / out-of-range cases
// plus randomized request and clear traffic checked against a
// transaction-level reference model (pending set, round-robin pointer).
module tb_reg_bank_write_arbiter;

  localparam int L  = 24;
  localparam int N  = 4;
  localparam int R  = 8;
  localparam int AW = $clog2(R);
  localparam int R6 = 6;
  localparam int AW6 = $clog2(R6);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (R=8)
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*L-1:0]  req_data = '0;
  logic            clr_req = 1'b0;
  logic [N-1:0]    gnt;
  logic            clr_done;
  logic [R-1:0]    reg_ena;
  logic [L-1:0]    reg_d;
  logic            busy;

  reg_bank_write_arbiter #(.L(L), .N(N), .R(R)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .req_data(req_data), .clr_req(clr_req), .gnt(gnt),
    .clr_done(clr_done), .reg_ena(reg_ena), .reg_d(reg_d), .busy(busy)
  );

  // Second instance with a non-power-of-two bank (R=6)
  logic [N-1:0]     req6 = '0;
  logic [N*AW6-1:0] req_addr6 = '0;
  logic [N*L-1:0]   req_data6 = '0;
  logic             clr_req6 = 1'b0;
  logic [N-1:0]     gnt6;
  logic             clr_done6;
  logic [R6-1:0]    reg_ena6;
  logic [L-1:0]     reg_d6;
  logic             busy6;

  reg_bank_write_arbiter #(.L(L), .N(N), .R(R6)) dut6 (
    .clk(clk), .rst_n(rst_n), .req(req6), .req_addr(req_addr6),
    .req_data(req_data6), .clr_req(clr_req6), .gnt(gnt6),
    .clr_done(clr_done6), .reg_ena(reg_ena6), .reg_d(reg_d6), .busy(busy6)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          pend [N];
  int          m_addr [N];
  logic [L-1:0] m_data [N];
  int          m_ptr;
  logic [L-1:0] m_last_d;

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req[i] = pend[i];
      req_addr[i*AW +: AW] = AW'(m_addr[i]);
      req_data[i*L +: L]   = m_data[i];
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_gnt"}, 64'(gnt), 64'd0);
    check_val({tag, "_ena"}, 64'(reg_ena), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_d"}, 64'(reg_d), 64'(m_last_d));
  endtask

  initial begin
    int w;
    bool_dummy: begin end
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; m_addr[i] = 0; m_data[i] = '0;
    end
    m_ptr = 0;
    m_last_d = '0;

    // Reset state
    #3;
    check_val("rst_gnt", 64'(gnt), 64'd0);
    check_val("rst_ena", 64'(reg_ena), 64'd0);
    check_val("rst_d", 64'(reg_d), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset during a grant cycle
    @(negedge clk);
    req = 4'b0010;
    req_addr[1*AW +: AW] = AW'(3);
    req_data[1*L +: L] = 24'h123456;
    @(posedge clk); #1;
    check_val("pre_rst_gnt", 64'(gnt), 64'h2);
    rst_n = 1'b0;
    #1;
    check_val("arst_gnt", 64'(gnt), 64'd0);
    check_val("arst_ena", 64'(reg_ena), 64'd0);
    check_val("arst_d", 64'(reg_d), 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset-during-grant done");

    // Randomized traffic; every iteration starts at a negedge in IDLE
    for (int t = 0; t < 300; t++) begin
      bit do_clr;
      do_clr = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]   = 1;
          m_addr[i] = $urandom_range(0, R - 1);
          m_data[i] = L'($urandom);
        end
      end
      if (!do_clr && !(pend[0] | pend[1] | pend[2] | pend[3])) begin
        w = $urandom_range(0, N - 1);
        pend[w] = 1; m_addr[w] = $urandom_range(0, R - 1); m_data[w] = L'($urandom);
      end
      clr_req = do_clr;
      drive_reqs();

      if (do_clr) begin
        for (int c = 0; c < R; c++) begin
          @(negedge clk);
          check_val("clr_ena", 64'(reg_ena), 64'(1) << c);
          check_val("clr_d", 64'(reg_d), 64'd0);
          check_val("clr_gnt", 64'(gnt), 64'd0);
          check_val("clr_busy", 64'(busy), 64'd1);
          check_val("clr_done_early", 64'(clr_done), 64'd0);
        end
        @(negedge clk);
        check_val("clr_done", 64'(clr_done), 64'd1);
        check_val("done_ena", 64'(reg_ena), 64'd0);
        check_val("done_gnt", 64'(gnt), 64'd0);
        clr_req = 1'b0;
        m_last_d = '0;
        @(negedge clk);
        check_val("post_done", 64'(clr_done), 64'd0);
        check_idle("post_clr");
        $display("txn %0d clear", t);
      end else begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (w < 0 && pend[idx]) w = idx;
        end
        @(negedge clk);
        check_val("gnt", 64'(gnt), 64'(1) << w);
        check_val("ena", 64'(reg_ena), 64'(1) << m_addr[w]);
        check_val("d", 64'(reg_d), 64'(m_data[w]));
        check_val("busy", 64'(busy), 64'd1);
        $display("txn %0d grant req=%0d addr=%0d data=%06h", t, w, m_addr[w], m_data[w]);
        m_last_d = m_data[w];
        pend[w] = 0;
        m_ptr = (w + 1) % N;
        drive_reqs();
        @(negedge clk);
        check_idle("post_gnt");
      end
    end
    req = '0;
    clr_req = 1'b0;

    // R=6 instance: out-of-range address is granted but not written
    @(negedge clk);
    req6 = 4'b0001;
    req_addr6[0 +: AW6] = AW6'(7);
    req_data6[0 +: L] = 24'hABCDEF;
    @(negedge clk);
    check_val("r6_oor_gnt", 64'(gnt6), 64'h1);
    check_val("r6_oor_ena", 64'(reg_ena6), 64'd0);
    req_addr6[0 +: AW6] = AW6'(5);
    req_data6[0 +: L] = 24'h00BEEF;
    @(negedge clk);
    check_val("r6_gap_gnt", 64'(gnt6), 64'd0);
    @(negedge clk);
    check_val("r6_gnt", 64'(gnt6), 64'h1);
    check_val("r6_ena", 64'(reg_ena6), 64'h20);
    check_val("r6_d", 64'(reg_d6), 64'h00BEEF);
    req6 = '0;
    $display("txn r6 out-of-range and addr5 writes");
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
